// File: rtl/game_pkg.sv
// Shared types for the bullet engine: coordinate width, position and
// velocity packing, colour codes, FSM encoding and small arithmetic helpers.
package game_pkg;

    localparam int COORD_W = 8;
    localparam int POS_W   = 2 * COORD_W;

    // Position is packed {x, y}; velocity is {dx, dy}, each two's complement.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    typedef struct packed {
        logic [3:0] dx;
        logic [3:0] dy;
    } vel_t;

    typedef enum logic [2:0] {
        C_WHITE  = 3'd0,
        C_RED    = 3'd1,
        C_GREEN  = 3'd2,
        C_BLUE   = 3'd3,
        C_YELLOW = 3'd4,
        C_CYAN   = 3'd5,
        C_PURPLE = 3'd6,
        C_ORANGE = 3'd7
    } color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [8:0] sext4(input logic [3:0] v);
        return {{5{v[3]}}, v};
    endfunction

    // v is 9-bit signed; bit 8 set means the move went negative.
    function automatic logic in_arena(input logic [8:0] v,
                                      input logic [7:0] lo,
                                      input logic [7:0] hi);
        return !v[8] && (v[7:0] >= lo) && (v[7:0] <= hi);
    endfunction

endpackage

// File: rtl/bullet_engine_if.sv
// Spawn handshake bundle: valid/ready plus the new bullet's
// position {x,y}, velocity {dx,dy} and colour code.
interface bullet_engine_if;

    logic        spawn_valid;
    logic        spawn_ready;
    logic [15:0] spawn_pos;
    logic [7:0]  spawn_vel;
    logic [2:0]  spawn_color;

    modport master (
        output spawn_valid, spawn_pos, spawn_vel, spawn_color,
        input  spawn_ready
    );

    modport slave (
        input  spawn_valid, spawn_pos, spawn_vel, spawn_color,
        output spawn_ready
    );

endinterface

// File: rtl/bullet_step.sv
// Combinational move/bounds/collision for one bullet slot.
// Ports: pos_i/vel_i slot state, player_i player {x,y};
// pos_o moved position, keep_o still in arena, hit_o touches player.
module bullet_step
    import game_pkg::*;
#(
    parameter logic [7:0] ARENA_MIN = 8'd20,
    parameter logic [7:0] ARENA_MAX = 8'd200,
    parameter int         HIT_R     = 4
) (
    input  pos_t pos_i,
    input  vel_t vel_i,
    input  pos_t player_i,
    output pos_t pos_o,
    output logic keep_o,
    output logic hit_o
);

    logic [8:0] nx, ny;
    logic [9:0] ddx, ddy;
    logic [9:0] ax, ay;

    // 9-bit signed moves: bit 8 flags a negative coordinate.
    assign nx = {1'b0, pos_i.x} + sext4(vel_i.dx);
    assign ny = {1'b0, pos_i.y} + sext4(vel_i.dy);

    assign keep_o = in_arena(nx, ARENA_MIN, ARENA_MAX)
                 && in_arena(ny, ARENA_MIN, ARENA_MAX);

    assign pos_o = {nx[7:0], ny[7:0]};

    assign ddx = {nx[8], nx} - {2'b00, player_i.x};
    assign ddy = {ny[8], ny} - {2'b00, player_i.y};
    assign ax  = ddx[9] ? 10'(-ddx) : ddx;
    assign ay  = ddy[9] ? 10'(-ddy) : ddy;

    assign hit_o = keep_o
                && (ax <= 10'(HIT_R))
                && (ay <= 10'(HIT_R));

endmodule

// File: rtl/bullet_engine.sv
// Bullet slot table: spawns into the lowest free slot, sweeps one slot per
// cycle on each tick, frees bullets that leave the arena or hit the player.
// Ports: clk/reset, tick frame strobe, clear, spawn handshake (interface),
// player_pos, rd_index/rd_data render port, active_mask, hit/hit_index,
// frame_done pulse, sticky overrun.
module bullet_engine
    import game_pkg::*;
#(
    parameter int         NUM_BULLETS = 8,
    parameter logic [7:0] ARENA_MIN   = 8'd20,
    parameter logic [7:0] ARENA_MAX   = 8'd200,
    parameter int         HIT_R       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   clear,
    bullet_engine_if.slave         spawn,
    input  logic [15:0]            player_pos,
    input  logic [3:0]             rd_index,
    output logic [19:0]            rd_data,
    output logic [NUM_BULLETS-1:0] active_mask,
    output logic                   hit,
    output logic [3:0]             hit_index,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int IW = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BULLETS - 1);

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [NUM_BULLETS-1:0] active_q;
    pos_t                   pos_q   [NUM_BULLETS];
    vel_t                   vel_q   [NUM_BULLETS];
    logic [2:0]             color_q [NUM_BULLETS];
    logic                   hit_q, frame_done_q, overrun_q;
    logic [3:0]             hit_index_q;
    logic [19:0]            rd_data_q, rd_data_d;

    logic [IW-1:0] free_idx;
    logic          ready;
    logic          fire;
    logic [IW-1:0] rs;
    pos_t          step_pos;
    logic          step_keep, step_hit;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!active_q[i]) free_idx = IW'(i);
        end
    end

    assign ready = !reset && !clear && (state_q == IDLE) && !(&active_q);
    assign spawn.spawn_ready = ready;
    assign fire = spawn.spawn_valid && ready;

    assign rs = rd_index[IW-1:0];

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_index) < NUM_BULLETS) begin
            rd_data_d = {active_q[rs], color_q[rs], pos_q[rs]};
        end
    end

    // One shared step unit, steered by the sweep index.
    bullet_step #(
        .ARENA_MIN(ARENA_MIN),
        .ARENA_MAX(ARENA_MAX),
        .HIT_R    (HIT_R)
    ) u_step (
        .pos_i   (pos_q[idx_q]),
        .vel_i   (vel_q[idx_q]),
        .player_i(player_pos),
        .pos_o   (step_pos),
        .keep_o  (step_keep),
        .hit_o   (step_hit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            active_q     <= '0;
            hit_q        <= 1'b0;
            hit_index_q  <= '0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            rd_data_q    <= '0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                pos_q[i]   <= '0;
                vel_q[i]   <= '0;
                color_q[i] <= '0;
            end
        end else begin
            hit_q        <= 1'b0;
            frame_done_q <= 1'b0;
            rd_data_q    <= rd_data_d;
            if (clear) begin
                state_q  <= IDLE;
                idx_q    <= '0;
                active_q <= '0;
            end else begin
                if (tick && state_q != IDLE) overrun_q <= 1'b1;
                unique case (state_q)
                    IDLE: begin
                        if (fire) begin
                            active_q[free_idx] <= 1'b1;
                            pos_q[free_idx]    <= spawn.spawn_pos;
                            vel_q[free_idx]    <= spawn.spawn_vel;
                            color_q[free_idx]  <= spawn.spawn_color;
                        end
                        if (tick) begin
                            state_q <= SWEEP;
                            idx_q   <= '0;
                        end
                    end
                    SWEEP: begin
                        if (active_q[idx_q]) begin
                            if (step_keep) pos_q[idx_q] <= step_pos;
                            if (!step_keep || step_hit) active_q[idx_q] <= 1'b0;
                            if (step_hit) begin
                                hit_q       <= 1'b1;
                                hit_index_q <= 4'(idx_q);
                            end
                        end
                        if (idx_q == LAST) state_q <= DONE;
                        else idx_q <= idx_q + 1'b1;
                    end
                    DONE: begin
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign active_mask = active_q;
    assign hit         = hit_q;
    assign hit_index   = hit_index_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Self-checking bench for bullet_engine: directed scenarios plus random
// frames, compared against a slot-list model of the game rules.
module tb_bullet_engine;

    localparam int NUM  = 8;
    localparam int AMIN = 20;
    localparam int AMAX = 200;
    localparam int HR   = 4;

    logic        clk = 1'b0;
    logic        reset, tick, clear;
    logic [15:0] player_pos;
    logic [3:0]  rd_index;
    logic [19:0] rd_data;
    logic [7:0]  active_mask;
    logic        hit;
    logic [3:0]  hit_index;
    logic        frame_done, overrun;

    bullet_engine_if sif();

    bullet_engine dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .clear      (clear),
        .spawn      (sif),
        .player_pos (player_pos),
        .rd_index   (rd_index),
        .rd_data    (rd_data),
        .active_mask(active_mask),
        .hit        (hit),
        .hit_index  (hit_index),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit m_act [NUM];
    int m_x   [NUM];
    int m_y   [NUM];
    int m_dx  [NUM];
    int m_dy  [NUM];
    int m_col [NUM];
    bit m_ovr;
    int exp_hits[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sx4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NUM; i++) if (!m_act[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_mask();
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < NUM; i++) m[i] = m_act[i];
        return m;
    endfunction

    function automatic void m_clear_all();
        for (int i = 0; i < NUM; i++) m_act[i] = 1'b0;
    endfunction

    // Game rules: move, drop if outside the arena, drop and record hits.
    function automatic void model_sweep();
        int px = int'(player_pos[15:8]);
        int py = int'(player_pos[7:0]);
        exp_hits.delete();
        for (int i = 0; i < NUM; i++) begin
            if (m_act[i]) begin
                int nx = m_x[i] + m_dx[i];
                int ny = m_y[i] + m_dy[i];
                if (nx < 0 || ny < 0 || nx < AMIN || ny < AMIN ||
                    nx > AMAX || ny > AMAX) begin
                    m_act[i] = 1'b0;
                end else begin
                    m_x[i] = nx;
                    m_y[i] = ny;
                    if (iabs(nx - px) <= HR && iabs(ny - py) <= HR) begin
                        m_act[i] = 1'b0;
                        exp_hits.push_back(i);
                    end
                end
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        m_clear_all();
        m_ovr = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(sif.spawn_ready), 32'd0);
        chk("rst_mask", 32'(active_mask), 32'd0);
        chk("rst_rd", 32'(rd_data), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
    endtask

    task automatic do_spawn(input logic [15:0] p, input logic [7:0] v,
                            input logic [2:0] c);
        int f;
        @(negedge clk);
        sif.spawn_valid = 1'b1;
        sif.spawn_pos   = p;
        sif.spawn_vel   = v;
        sif.spawn_color = c;
        f = m_free();
        #1;
        chk("spawn_ready", 32'(sif.spawn_ready), 32'(f >= 0));
        if (f >= 0) begin
            m_act[f] = 1'b1;
            m_x[f]   = int'(p[15:8]);
            m_y[f]   = int'(p[7:0]);
            m_dx[f]  = sx4(v[7:4]);
            m_dy[f]  = sx4(v[3:0]);
            m_col[f] = int'(c);
        end
        @(negedge clk);
        sif.spawn_valid = 1'b0;
        chk("mask_spawn", 32'(active_mask), 32'(m_mask()));
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_clear_all();
        chk("mask_clear", 32'(active_mask), 32'd0);
    endtask

    // tick2 > 0 drives a second tick that many cycles after the first.
    task automatic run_frame(input int tick2);
        int got[$];
        int fd_cnt = 0;
        int fd_at  = -1;
        int n;
        model_sweep();
        if (tick2 > 0) m_ovr = 1'b1;
        @(negedge clk);
        tick = 1'b1;
        for (int c = 1; c <= NUM + 6; c++) begin
            @(negedge clk);
            if (hit === 1'b1) got.push_back(int'(hit_index));
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_at = c;
            end
            tick = (c == tick2);
        end
        tick = 1'b0;
        chk("fd_count", 32'(fd_cnt), 32'd1);
        chk("fd_latency", 32'(fd_at), 32'(NUM + 2));
        chk("hit_count", 32'(got.size()), 32'(exp_hits.size()));
        n = (got.size() < exp_hits.size()) ? got.size() : exp_hits.size();
        for (int i = 0; i < n; i++) begin
            chk("hit_index", 32'(got[i]), 32'(exp_hits[i]));
        end
        chk("mask_frame", 32'(active_mask), 32'(m_mask()));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_index = 4'(i);
            @(negedge clk);
            if (i >= NUM) begin
                chk("rd_oob", 32'(rd_data), 32'd0);
            end else if (m_act[i]) begin
                chk("rd_slot", 32'(rd_data),
                    32'({1'b1, 3'(m_col[i]), 8'(m_x[i]), 8'(m_y[i])}));
            end else begin
                chk("rd_free", 32'(rd_data[19]), 32'd0);
            end
        end
    endtask

    initial begin
        int fd, hc, px, py;
        logic [15:0] p;
        reset           = 1'b1;
        tick            = 1'b0;
        clear           = 1'b0;
        sif.spawn_valid = 1'b0;
        sif.spawn_pos   = '0;
        sif.spawn_vel   = '0;
        sif.spawn_color = '0;
        player_pos      = '0;
        rd_index        = '0;

        do_reset();

        // Single bullet moving +1 in x.
        player_pos = 16'h3030;
        do_spawn(16'h5050, 8'h10, 3'd2);
        run_frame(-1);
        @(negedge clk);
        rd_index = 4'd0;
        @(negedge clk);
        chk("move_rd0", 32'(rd_data), 32'h000A5150);

        // Bullet at the right edge leaves the arena.
        do_spawn(16'hC850, 8'h10, 3'd1);
        run_frame(-1);
        read_all();

        // Two collisions in one sweep, slots 2 and 5.
        do_reset();
        player_pos = 16'h6464;
        do_spawn(16'h3030, 8'h00, 3'd0);
        do_spawn(16'h3030, 8'h00, 3'd0);
        do_spawn(16'h6060, 8'h00, 3'd3);
        do_spawn(16'h3030, 8'h00, 3'd0);
        do_spawn(16'h3030, 8'h00, 3'd0);
        do_spawn(16'h6464, 8'h00, 3'd4);
        run_frame(-1);

        // Fill every slot; the ninth spawn must be refused.
        do_reset();
        for (int k = 0; k < NUM + 1; k++) begin
            do_spawn({8'($urandom_range(40, 180)), 8'($urandom_range(40, 180))},
                     8'($urandom), 3'($urandom));
        end

        // Second tick during the sweep.
        run_frame(3);

        // clear in the middle of a sweep.
        do_reset();
        player_pos = 16'h3030;
        for (int k = 0; k < 3; k++) do_spawn(16'h9090, 8'h00, 3'd5);
        @(negedge clk);
        tick = 1'b1;
        fd = 0;
        for (int c = 1; c <= NUM + 6; c++) begin
            @(negedge clk);
            tick = 1'b0;
            if (frame_done === 1'b1) fd++;
            if (c == 4) clear = 1'b1;
            if (c == 5) begin
                clear = 1'b0;
                chk("clr_mask", 32'(active_mask), 32'd0);
            end
        end
        m_clear_all();
        chk("clr_no_fd", 32'(fd), 32'd0);
        chk("clr_idle", 32'(sif.spawn_ready), 32'd1);

        // Reset in the middle of a sweep full of pending hits.
        do_reset();
        player_pos = 16'h6464;
        for (int k = 0; k < 4; k++) do_spawn(16'h6464, 8'h00, 3'd1);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick  = 1'b0;
        reset = 1'b1;
        fd = 0;
        hc = 0;
        repeat (NUM + 6) begin
            @(negedge clk);
            if (hit === 1'b1) hc++;
            if (frame_done === 1'b1) fd++;
        end
        reset = 1'b0;
        m_clear_all();
        m_ovr = 1'b0;
        chk("rsw_hits", 32'(hc), 32'd0);
        chk("rsw_fd", 32'(fd), 32'd0);
        chk("rsw_mask", 32'(active_mask), 32'd0);

        // Random frames.
        for (int it = 0; it < 40; it++) begin
            px = $urandom_range(30, 190);
            py = $urandom_range(30, 190);
            player_pos = {8'(px), 8'(py)};
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                if ($urandom_range(0, 2) == 0) begin
                    p = {8'(px + int'($urandom_range(0, 10)) - 5),
                         8'(py + int'($urandom_range(0, 10)) - 5)};
                end else begin
                    p = 16'($urandom);
                end
                do_spawn(p, 8'($urandom), 3'($urandom));
            end
            if ($urandom_range(0, 9) == 0) do_clear();
            run_frame(-1);
            if (it % 10 == 9) read_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
